// File: rtl/decoder_pkg.sv
// -----------------------------------------------------------------------------
// decoder_pkg
// Shared parameters and types for the binarized decoder hidden-state layer.
//   IN_W      : hidden vector / weight row width
//   OUT_W     : number of output neurons (power of two)
//   NUM_STEPS : time steps per sequence
//   BANK_W    : weight bank select width
// -----------------------------------------------------------------------------
package decoder_pkg;
    localparam int IN_W      = 256;
    localparam int OUT_W     = 16;
    localparam int NUM_STEPS = 30;
    localparam int BANK_W    = 2;

    localparam int NIDX_W = $clog2(OUT_W);       // neuron index width
    localparam int ADDR_W = BANK_W + NIDX_W;     // ROM address {bank, neuron}
    localparam int CNT_W  = $clog2(IN_W) + 1;    // popcount width (0..IN_W)
    localparam int STEP_W = 5;                   // time-step counter width

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;
endpackage

// File: rtl/popcount_256.sv
// -----------------------------------------------------------------------------
// popcount_256
// Combinational binary adder tree counting the ones in in_vec.
//   in_vec : IN_W-bit input vector
//   count  : number of set bits, CNT_W bits wide (0..IN_W)
// Level l holds IN_W>>l partial sums, each l+1 bits wide.
// -----------------------------------------------------------------------------
module popcount_256
    import decoder_pkg::*;
#(
    parameter int P_IN_W = IN_W
) (
    input  logic [P_IN_W-1:0]          in_vec,
    output logic [$clog2(P_IN_W):0]    count
);
    localparam int LVLS = $clog2(P_IN_W);

    genvar l, i;
    generate
        for (l = 0; l <= LVLS; l++) begin : g_lvl
            logic [l:0] s [0:(P_IN_W>>l)-1];
            if (l == 0) begin : g_leaf
                for (i = 0; i < P_IN_W; i++) begin : g_bit
                    assign s[i] = in_vec[i];
                end
            end else begin : g_sum
                for (i = 0; i < (P_IN_W>>l); i++) begin : g_add
                    assign s[i] = {1'b0, g_lvl[l-1].s[2*i]} + {1'b0, g_lvl[l-1].s[2*i+1]};
                end
            end
        end
    endgenerate

    assign count = g_lvl[LVLS].s[0];
endmodule

// File: rtl/decoder_hidden_state_1.sv
// -----------------------------------------------------------------------------
// decoder_hidden_state_1
// Binarized XNOR-popcount decoder layer. Accepts one IN_W-bit hidden vector per
// time step, reads OUT_W weight rows serially from an external synchronous ROM
// and emits an OUT_W-bit binary result. Counts steps; done is sticky.
//   clk, rst_n      : clock, async active-low reset
//   clear           : sync abort, zeroes step counter and done
//   block_sel       : weight bank, sampled at accept
//   in_data/in_valid/in_ready : hidden vector handshake
//   w_addr/w_en     : ROM read port {bank, neuron}, registered
//   w_data          : ROM row, valid one cycle after w_addr/w_en
//   data_out/data_out_valid : result vector and one-cycle strobe
//   done            : NUM_STEPS vectors completed
// -----------------------------------------------------------------------------
module decoder_hidden_state_1
    import decoder_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic [BANK_W-1:0]    block_sel,
    input  logic [IN_W-1:0]      in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [ADDR_W-1:0]    w_addr,
    output logic                 w_en,
    input  logic [IN_W-1:0]      w_data,
    output logic [OUT_W-1:0]     data_out,
    output logic                 data_out_valid,
    output logic                 done
);
    localparam logic [NIDX_W:0]  K_LAST    = (NIDX_W+1)'(OUT_W);
    localparam logic [NIDX_W:0]  K_LASTRD  = (NIDX_W+1)'(OUT_W - 1);
    localparam logic [CNT_W-1:0] HALF      = CNT_W'(IN_W / 2);
    localparam logic [STEP_W-1:0] STEP_END = STEP_W'(NUM_STEPS);

    state_t              r_state;
    logic [IN_W-1:0]     r_vec;
    logic [BANK_W-1:0]   r_bank;
    logic [NIDX_W:0]     r_k;
    logic [OUT_W-2:0]    r_res;      // final bit goes straight to data_out
    logic [STEP_W-1:0]   r_step;
    logic [ADDR_W-1:0]   r_waddr;
    logic                r_wen;
    logic [OUT_W-1:0]    r_dout;
    logic                r_dvalid;
    logic                r_done;

    logic [CNT_W-1:0]    w_pop;
    logic                w_bit;
    logic [NIDX_W-1:0]   w_knext;
    logic [NIDX_W-1:0]   w_kprev;
    logic [STEP_W-1:0]   w_step_inc;

    // One shared popcount; w_data during cycle k belongs to neuron k-1.
    popcount_256 #(.P_IN_W(IN_W)) u_pop (
        .in_vec (~(r_vec ^ w_data)),
        .count  (w_pop)
    );

    assign w_bit      = (w_pop > HALF);      // tie maps to 0
    assign w_knext    = r_k[NIDX_W-1:0] + NIDX_W'(1);
    assign w_kprev    = r_k[NIDX_W-1:0] - NIDX_W'(1);
    assign w_step_inc = r_step + STEP_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_vec    <= '0;
            r_bank   <= '0;
            r_k      <= '0;
            r_res    <= '0;
            r_step   <= '0;
            r_waddr  <= '0;
            r_wen    <= 1'b0;
            r_dout   <= '0;
            r_dvalid <= 1'b0;
            r_done   <= 1'b0;
        end else if (clear) begin
            // Abort: data_out keeps its last value, no strobe for the run.
            r_state  <= IDLE;
            r_step   <= '0;
            r_done   <= 1'b0;
            r_dvalid <= 1'b0;
            r_wen    <= 1'b0;
        end else begin
            r_dvalid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (in_valid && !r_done) begin
                        r_vec   <= in_data;
                        r_bank  <= block_sel;
                        r_k     <= '0;
                        r_wen   <= 1'b1;
                        r_waddr <= {block_sel, NIDX_W'(0)};
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_k <= r_k + 1'b1;
                    // Address for cycle k+1 is set up at the end of cycle k.
                    if (r_k < K_LASTRD) begin
                        r_wen   <= 1'b1;
                        r_waddr <= {r_bank, w_knext};
                    end else begin
                        r_wen   <= 1'b0;
                    end
                    if (r_k != '0 && r_k < K_LAST)
                        r_res[w_kprev] <= w_bit;
                    if (r_k == K_LAST) begin
                        r_dout   <= {w_bit, r_res};
                        r_dvalid <= 1'b1;
                        r_step   <= w_step_inc;
                        if (w_step_inc == STEP_END)
                            r_done <= 1'b1;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready       = (r_state == IDLE) && !r_done;
    assign w_addr         = r_waddr;
    assign w_en           = r_wen;
    assign data_out       = r_dout;
    assign data_out_valid = r_dvalid;
    assign done           = r_done;
endmodule
